// File: rtl/playground_pkg.sv
// Shared types and constants for the 16x4 RAM arbiter.
// Holds the FSM state encoding, port identifiers and default RAM geometry.
package playground_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        READ  = 2'd2
    } arb_state_t;

    localparam logic PORT_HOST = 1'b0;
    localparam logic PORT_AUX  = 1'b1;

    localparam int RAM_ADDR_W = 4;
    localparam int RAM_DATA_W = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-input picker with a last_grant flop; round-robin on ties unless FIXED_PRIO
// is set, in which case port 0 always wins a tie.
module rr_arb2
    import playground_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic       pick,
    output logic       any
);

    logic last_grant_r;

    // Remember who won the most recent grant; reset favours port 0 on the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= PORT_AUX;
        end else if (en && any) begin
            last_grant_r <= pick;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Winner selection from the current requests.
    always_comb begin
        any  = |req;
        pick = PORT_HOST;
        case (req)
            2'b01:   pick = PORT_HOST;
            2'b10:   pick = PORT_AUX;
            2'b11: begin
                if (FIXED_PRIO != 0) begin
                    pick = PORT_HOST;
                end else begin
                    pick = ~last_grant_r;
                end
            end
            default: pick = PORT_HOST;
        endcase
    end

endmodule

// File: rtl/ram16x4_arbiter.sv
// Serialises host and internal requests onto a single synchronous RAM port
// and routes read data back to whichever requester issued the read.
module ram16x4_arbiter
    import playground_pkg::*;
#(
    parameter int ADDR_W     = RAM_ADDR_W,
    parameter int DATA_W     = RAM_DATA_W,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_t        state_r;
    logic              owner_r;
    logic              is_read_r;
    logic              arb_pick_s;
    logic              arb_any_s;
    logic              arb_en_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    assign arb_en_s = (state_r == IDLE);

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  ({req1, req0}),
        .en   (arb_en_s),
        .pick (arb_pick_s),
        .any  (arb_any_s)
    );

    // Steer the winning requester's fields toward the RAM registers.
    always_comb begin
        sel_we_s    = we0;
        sel_addr_s  = addr0;
        sel_wdata_s = wdata0;
        if (arb_pick_s == PORT_AUX) begin
            sel_we_s    = we1;
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_we_s    = we0;
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end
    end

    // Access sequencer: every output is a flop, so req never reaches gnt or ram_* combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            owner_r   <= PORT_HOST;
            is_read_r <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= {DATA_W{1'b0}};
            rdata1    <= {DATA_W{1'b0}};
            busy      <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= {ADDR_W{1'b0}};
            ram_wdata <= {DATA_W{1'b0}};
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (arb_any_s) begin
                        owner_r   <= arb_pick_s;
                        is_read_r <= ~sel_we_s;
                        ram_we    <= sel_we_s;
                        ram_addr  <= sel_addr_s;
                        ram_wdata <= sel_wdata_s;
                        gnt0      <= (arb_pick_s == PORT_HOST);
                        gnt1      <= (arb_pick_s == PORT_AUX);
                        busy      <= 1'b1;
                        state_r   <= ISSUE;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    ram_we <= 1'b0;
                    if (is_read_r) begin
                        busy    <= 1'b1;
                        state_r <= READ;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    // RAM data sampled at the previous edge is valid now.
                    if (owner_r == PORT_AUX) begin
                        rdata1  <= ram_rdata;
                        rvalid1 <= 1'b1;
                    end else begin
                        rdata0  <= ram_rdata;
                        rvalid0 <= 1'b1;
                    end
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    ram_we  <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram16x4_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority instance share
// stimulus, each with its own behavioural 16x4 RAM.
module tb_ram16x4_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [3:0] addr0, addr1, wdata0, wdata1;

    logic       gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, busy_a, ram_we_a;
    logic [3:0] rdata0_a, rdata1_a, ram_addr_a, ram_wdata_a, ram_rdata_a;
    logic       gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, busy_b, ram_we_b;
    logic [3:0] rdata0_b, rdata1_b, ram_addr_b, ram_wdata_b, ram_rdata_b;

    logic [3:0] mem_a [16];
    logic [3:0] mem_b [16];

    int errors;
    int checks;
    int rv0_count;
    int rv0_before;

    ram16x4_arbiter #(.ADDR_W(4), .DATA_W(4), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .rvalid0(rvalid0_a), .rvalid1(rvalid1_a),
        .rdata0(rdata0_a), .rdata1(rdata1_a), .busy(busy_a),
        .ram_we(ram_we_a), .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a),
        .ram_rdata(ram_rdata_a)
    );

    ram16x4_arbiter #(.ADDR_W(4), .DATA_W(4), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .rvalid0(rvalid0_b), .rvalid1(rvalid1_b),
        .rdata0(rdata0_b), .rdata1(rdata1_b), .busy(busy_b),
        .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b),
        .ram_rdata(ram_rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAMs with one-cycle registered read.
    always @(posedge clk) begin
        if (ram_we_a) mem_a[ram_addr_a] <= ram_wdata_a;
        ram_rdata_a <= mem_a[ram_addr_a];
        if (ram_we_b) mem_b[ram_addr_b] <= ram_wdata_b;
        ram_rdata_b <= mem_b[ram_addr_b];
        if (rvalid0_a) rv0_count <= rv0_count + 1;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        errors = 0; checks = 0; rv0_count = 0;
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 4'h0;
            mem_b[i] = 4'h0;
        end
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 4'h0; addr1 = 4'h0; wdata0 = 4'h0; wdata1 = 4'h0;
        step(); step();
        check("rst_gnt0", {7'd0, gnt0_a}, 8'd0);
        check("rst_busy", {7'd0, busy_a}, 8'd0);
        check("rst_ram_we", {7'd0, ram_we_a}, 8'd0);
        check("rst_ram_addr", {4'd0, ram_addr_a}, 8'd0);
        check("rst_ram_wdata", {4'd0, ram_wdata_a}, 8'd0);
        check("rst_rdata0", {4'd0, rdata0_a}, 8'd0);
        check("rst_rvalid1", {7'd0, rvalid1_a}, 8'd0);
        rst = 1'b0;

        // Host write of A to word 3
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 4'hA;
        step();
        check("wr_gnt0", {7'd0, gnt0_a}, 8'd1);
        check("wr_gnt1", {7'd0, gnt1_a}, 8'd0);
        check("wr_ram_we", {7'd0, ram_we_a}, 8'd1);
        check("wr_ram_addr", {4'd0, ram_addr_a}, 8'd3);
        check("wr_ram_wdata", {4'd0, ram_wdata_a}, 8'hA);
        check("wr_busy", {7'd0, busy_a}, 8'd1);
        req0 = 1'b0;
        step();
        check("wr_ram_we_off", {7'd0, ram_we_a}, 8'd0);
        check("wr_gnt0_off", {7'd0, gnt0_a}, 8'd0);
        check("wr_busy_off", {7'd0, busy_a}, 8'd0);

        // Aux read back of word 3
        rv0_before = rv0_count;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd3;
        step();
        check("rd_gnt1", {7'd0, gnt1_a}, 8'd1);
        check("rd_ram_we", {7'd0, ram_we_a}, 8'd0);
        check("rd_ram_addr", {4'd0, ram_addr_a}, 8'd3);
        req1 = 1'b0;
        step();
        check("rd_gnt1_off", {7'd0, gnt1_a}, 8'd0);
        check("rd_rvalid1_early", {7'd0, rvalid1_a}, 8'd0);
        check("rd_busy_mid", {7'd0, busy_a}, 8'd1);
        step();
        check("rd_rvalid1", {7'd0, rvalid1_a}, 8'd1);
        check("rd_rdata1", {4'd0, rdata1_a}, 8'hA);
        check("rd_rvalid0", {7'd0, rvalid0_a}, 8'd0);
        step();
        check("rd_rvalid1_off", {7'd0, rvalid1_a}, 8'd0);
        check("rd_rdata1_hold", {4'd0, rdata1_a}, 8'hA);
        check("rd_busy_off", {7'd0, busy_a}, 8'd0);
        check("rd_no_rvalid0", rv0_count[7:0], rv0_before[7:0]);

        // Contention with both requests held high
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd5; wdata0 = 4'd1;
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'd6; wdata1 = 4'd2;
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_gnt0", {7'd0, gnt0_a}, (k % 2 == 0) ? 8'd1 : 8'd0);
            check("rr_gnt1", {7'd0, gnt1_a}, (k % 2 == 0) ? 8'd0 : 8'd1);
            check("rr_ram_addr", {4'd0, ram_addr_a}, (k % 2 == 0) ? 8'd5 : 8'd6);
            check("fp_gnt0", {7'd0, gnt0_b}, 8'd1);
            check("fp_gnt1", {7'd0, gnt1_b}, 8'd0);
            step();
            check("rr_gap_we", {7'd0, ram_we_a}, 8'd0);
            check("rr_gap_gnt", {6'd0, gnt1_a, gnt0_a}, 8'd0);
        end
        req0 = 1'b0;
        step();
        check("fp_gnt1_after_drop", {7'd0, gnt1_b}, 8'd1);
        check("fp_ram_addr_aux", {4'd0, ram_addr_b}, 8'd6);
        req1 = 1'b0;
        step(); step();
        check("rr_mem5", {4'd0, mem_a[5]}, 8'd1);
        check("rr_mem6", {4'd0, mem_a[6]}, 8'd2);

        // Aux read of word 6 so rdata1 holds a non-zero value
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd6;
        step();
        req1 = 1'b0;
        step(); step();
        check("pre_rdata1", {4'd0, rdata1_a}, 8'd2);
        step();

        // Host read of word 5 interrupted by reset in READ
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd5;
        step();
        check("mid_gnt0", {7'd0, gnt0_a}, 8'd1);
        req0 = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("mid_rvalid0", {7'd0, rvalid0_a}, 8'd0);
        check("mid_rdata0", {4'd0, rdata0_a}, 8'd0);
        check("mid_rdata1", {4'd0, rdata1_a}, 8'd0);
        check("mid_busy", {7'd0, busy_a}, 8'd0);
        rst = 1'b0;
        step();
        check("mid_rvalid0_after", {7'd0, rvalid0_a}, 8'd0);
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd7; wdata0 = 4'd3;
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'd8; wdata1 = 4'd4;
        step();
        check("mid_tie_gnt0", {7'd0, gnt0_a}, 8'd1);
        check("mid_tie_gnt1", {7'd0, gnt1_a}, 8'd0);
        req0 = 1'b0; req1 = 1'b0;
        step(); step();

        // One-cycle request pulse still commits
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd9; wdata0 = 4'd5;
        step();
        req0 = 1'b0;
        check("drop_gnt0", {7'd0, gnt0_a}, 8'd1);
        check("drop_ram_addr", {4'd0, ram_addr_a}, 8'd9);
        step();
        check("drop_ram_we_off", {7'd0, ram_we_a}, 8'd0);
        check("drop_busy", {7'd0, busy_a}, 8'd0);
        check("drop_mem9", {4'd0, mem_a[9]}, 8'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
